// File: rtl/core_lsu_pkg.sv
// Shared constants for the load/store unit: RV32I width codes, FSM encodings,
// exception cause codes and the funct3 legality helper.
package core_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_RWAIT = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10
  } exc_cause_e;

  function automatic logic f3_legal(input logic load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (load) begin
      case (f3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
        default:                             ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_SB, F3_SH, F3_SW: ok = 1'b1;
        default:             ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational datapath of the LSU: request fault check, store lane/strobe
// generation, and load byte-lane extraction with sign/zero extension.
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  logic        i_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic        o_fault,
  output logic [1:0]  o_cause,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic        w_misalign;
  logic [31:0] w_shift;

  // Fault classification; an illegal width code wins over misalignment
  always_comb begin
    w_misalign = 1'b0;
    case (i_funct3[1:0])
      2'b01:   w_misalign = i_addr_lo[0];
      2'b10:   w_misalign = |i_addr_lo;
      default: w_misalign = 1'b0;
    endcase
    if (!f3_legal(i_load, i_funct3)) begin
      o_cause = EXC_ILLEGAL;
    end else if (w_misalign) begin
      o_cause = EXC_MISALIGN;
    end else begin
      o_cause = EXC_NONE;
    end
    o_fault = (o_cause != EXC_NONE);
  end

  // Store strobes and lane-replicated write data
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_funct3[1:0])
      2'b00: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      2'b10: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    w_shift   = i_rdata >> {i_ld_addr_lo, 3'b000};
    o_ld_data = w_shift;
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_LH:   o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_LW:   o_ld_data = w_shift;
      F3_LBU:  o_ld_data = {24'h00_0000, w_shift[7:0]};
      F3_LHU:  o_ld_data = {16'h0000, w_shift[15:0]};
      default: o_ld_data = w_shift;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Memory-stage load/store unit: one request per handshake, word bus with byte
// strobes, extended load data delivered to the register-file write port.
module core_lsu
  import core_lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_load,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_done,
  output logic        o_exc,
  output logic [1:0]  o_exc_cause
);

  logic [2:0]  r_state;
  logic        r_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rd;
  logic        r_mem_valid;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_wdata;
  logic        r_wb_we;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        r_done;
  logic        r_exc;
  logic [1:0]  r_exc_cause;

  logic        w_accept;
  logic        w_fault;
  logic [1:0]  w_cause;
  logic [3:0]  w_st_strb;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;

  assign o_req_ready = (r_state == ST_IDLE);
  assign w_accept    = i_req_valid && o_req_ready;

  // Checks run on the incoming fields so a fault reaches FIN one edge after accept
  core_lsu_align u_align (
    .i_load       (i_req_load),
    .i_funct3     (i_req_funct3),
    .i_addr_lo    (i_req_addr[1:0]),
    .i_wdata      (i_req_wdata),
    .o_fault      (w_fault),
    .o_cause      (w_cause),
    .o_wstrb      (w_st_strb),
    .o_wdata      (w_st_data),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (i_mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  // FSM, bus request registers, write-back port and completion pulses
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_load      <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_rd        <= 5'd0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
      r_wb_we     <= 1'b0;
      r_wb_addr   <= 5'd0;
      r_wb_data   <= 32'h0000_0000;
      r_done      <= 1'b0;
      r_exc       <= 1'b0;
      r_exc_cause <= EXC_NONE;
    end else begin
      r_wb_we     <= 1'b0;
      r_done      <= 1'b0;
      r_exc       <= 1'b0;
      r_exc_cause <= EXC_NONE;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_load    <= i_req_load;
            r_funct3  <= i_req_funct3;
            r_addr_lo <= i_req_addr[1:0];
            r_rd      <= i_req_rd;
            if (w_fault) begin
              r_done      <= 1'b1;
              r_exc       <= 1'b1;
              r_exc_cause <= w_cause;
              r_state     <= ST_FIN;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_we    <= !i_req_load;
              r_mem_addr  <= {i_req_addr[31:2], 2'b00};
              r_mem_wstrb <= i_req_load ? 4'b0000 : w_st_strb;
              r_mem_wdata <= i_req_load ? 32'h0000_0000 : w_st_data;
              r_state     <= ST_REQ;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (i_mem_ready) begin
            r_mem_valid <= 1'b0;
            if (r_load) begin
              r_state <= ST_RWAIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_RWAIT: begin
          // Address and data stay put after the pulse for the late-sampling regfile
          if (i_mem_rvalid) begin
            r_wb_we   <= (r_rd != 5'd0);
            r_wb_addr <= r_rd;
            r_wb_data <= w_ld_data;
            r_state   <= ST_WB;
          end else begin
            r_state <= ST_RWAIT;
          end
        end
        ST_WB: begin
          r_done  <= 1'b1;
          r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_valid = r_mem_valid;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wstrb = r_mem_wstrb;
  assign o_mem_wdata = r_mem_wdata;
  assign o_wb_we     = r_wb_we;
  assign o_wb_addr   = r_wb_addr;
  assign o_wb_data   = r_wb_data;
  assign o_done      = r_done;
  assign o_exc       = r_exc;
  assign o_exc_cause = r_exc_cause;

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: directed vectors push expected bus, write-back
// and completion events; a negedge monitor pops and compares them.
module tb_core_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        i_req_valid, i_req_load;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [4:0]  i_req_rd;
  logic        o_req_ready;
  logic        o_mem_valid, o_mem_we;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_wstrb;
  logic        o_wb_we, o_done, o_exc;
  logic [4:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic [1:0]  o_exc_cause;

  always #5 CLK = ~CLK;

  core_lsu dut (
    .CLK(CLK), .RST_N(RST_N),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_load(i_req_load),
    .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_rd(i_req_rd),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .o_done(o_done), .o_exc(o_exc), .o_exc_cause(o_exc_cause)
  );

  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; int cyc; } mem_exp_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wb_exp_t;
  typedef struct { logic exc; logic [1:0] cause; int cyc; } done_exp_t;

  mem_exp_t  mem_q[$];
  wb_exp_t   wb_q[$];
  done_exp_t done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Monitor: pops expectations when the DUT presents bus, write-back or done events
  initial begin
    bit      hold;
    wb_exp_t last;
    hold = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (hold) begin
          check("wb_hold_addr", {27'd0, o_wb_addr}, {27'd0, last.addr});
          check("wb_hold_data", o_wb_data, last.data);
        end
        hold = 1'b0;
        if (o_mem_valid && i_mem_ready) begin
          if (mem_q.size() == 0) begin
            check("mem_unexpected", {31'd0, o_mem_valid}, 32'd0);
          end else begin
            mem_exp_t e;
            e = mem_q.pop_front();
            check("mem_we",    {31'd0, o_mem_we}, {31'd0, e.we});
            check("mem_addr",  o_mem_addr, e.addr);
            check("mem_wstrb", {28'd0, o_mem_wstrb}, {28'd0, e.strb});
            check("mem_wdata", o_mem_wdata, e.wdata);
            check("mem_cycle", cyc, e.cyc);
          end
        end
        if (o_wb_we) begin
          if (wb_q.size() == 0) begin
            check("wb_unexpected", {31'd0, o_wb_we}, 32'd0);
          end else begin
            last = wb_q.pop_front();
            check("wb_addr",  {27'd0, o_wb_addr}, {27'd0, last.addr});
            check("wb_data",  o_wb_data, last.data);
            check("wb_cycle", cyc, last.cyc);
            hold = 1'b1;
          end
        end
        if (o_done) begin
          if (done_q.size() == 0) begin
            check("done_unexpected", {31'd0, o_done}, 32'd0);
          end else begin
            done_exp_t d;
            d = done_q.pop_front();
            check("exc",        {31'd0, o_exc}, {31'd0, d.exc});
            check("exc_cause",  {30'd0, o_exc_cause}, {30'd0, d.cause});
            check("done_cycle", cyc, d.cyc);
          end
        end
        if (o_exc && !o_done) check("exc_without_done", {31'd0, o_done}, {31'd0, o_exc});
      end
    end
  end

  // One request with a scripted bus: rw cycles of READY low, vw cycles before RVALID
  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int rw, input int vw,
                       input logic [31:0] rdata, input logic [1:0] cause, input logic [3:0] strb,
                       input logic [31:0] mwd, input logic [31:0] wbd);
    int          t0;
    bit          got;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;
    i_req_valid = 1'b1; i_req_load = ld; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wd; i_req_rd = rd;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (o_req_ready) got = 1'b1;
    end
    if (!got) begin
      check("req_ready_timeout", {31'd0, o_req_ready}, 32'd1);
      i_req_valid = 1'b0;
      return;
    end
    t0 = cyc;
    if (cause != 2'b00) begin
      done_q.push_back('{1'b1, cause, t0 + 1});
    end else begin
      mem_q.push_back('{!ld, {addr[31:2], 2'b00}, strb, mwd, t0 + 1 + rw});
      if (ld && rd != 5'd0) wb_q.push_back('{rd, wbd, t0 + 3 + rw + vw});
      done_q.push_back('{1'b0, 2'b00, ld ? t0 + 4 + rw + vw : t0 + 2 + rw});
    end
    @(posedge CLK); #1;
    i_req_valid = 1'b0;
    if (cause == 2'b00) begin
      i_mem_ready = (rw == 0);
      s_addr = 32'd0; s_wdata = 32'd0; s_strb = 4'd0;
      for (int k = 0; k < rw; k++) begin
        @(negedge CLK);
        check("mem_valid_stall", {31'd0, o_mem_valid}, 32'd1);
        if (k == 0) begin
          s_addr = o_mem_addr; s_wdata = o_mem_wdata; s_strb = o_mem_wstrb;
        end else begin
          check("stall_addr",  o_mem_addr, s_addr);
          check("stall_wdata", o_mem_wdata, s_wdata);
          check("stall_wstrb", {28'd0, o_mem_wstrb}, {28'd0, s_strb});
        end
        @(posedge CLK); #1;
        if (k == rw - 1) i_mem_ready = 1'b1;
      end
      @(posedge CLK); #1;
      i_mem_ready = 1'b0;
      if (ld) begin
        for (int k = 0; k < vw; k++) begin
          @(posedge CLK); #1;
        end
        i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
        @(posedge CLK); #1;
        i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
      end
    end
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge CLK);
      if (o_done) got = 1'b1;
    end
    if (!got) check("done_timeout", {31'd0, o_done}, 32'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b0; i_req_valid = 1'b0; i_req_load = 1'b0; i_req_funct3 = 3'd0;
    i_req_addr = 32'd0; i_req_wdata = 32'd0; i_req_rd = 5'd0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
    check("rst_done",      {31'd0, o_done}, 32'd0);
    check("rst_wb_we",     {31'd0, o_wb_we}, 32'd0);
    check("rst_wb_data",   o_wb_data, 32'd0);
    check("rst_mem_wstrb", {28'd0, o_mem_wstrb}, 32'd0);
    mon_en = 1'b1;
    @(posedge CLK); #1;

    //    ld    f3      addr          wdata         rd     rw vw rdata         cause  strb     mem_wdata     wb_data
    do_op(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  0, 0, 32'h0,        2'b00, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    do_op(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0,  0, 0, 32'h0,        2'b00, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    do_op(1'b0, 3'b001, 32'h0000_0102, 32'h1234_CAFE, 5'd0,  1, 0, 32'h0,        2'b00, 4'b1100, 32'hCAFE_CAFE, 32'h0);
    do_op(1'b1, 3'b000, 32'h0000_0102, 32'h0,         5'd5,  0, 0, 32'h1280_3456, 2'b00, 4'b0000, 32'h0,         32'hFFFF_FF80);
    do_op(1'b1, 3'b100, 32'h0000_0102, 32'h0,         5'd5,  0, 0, 32'h1280_3456, 2'b00, 4'b0000, 32'h0,         32'h0000_0080);
    do_op(1'b1, 3'b001, 32'h0000_0101, 32'h0,         5'd6,  0, 0, 32'h0,        2'b01, 4'b0000, 32'h0,         32'h0);
    do_op(1'b1, 3'b011, 32'h0000_0100, 32'h0,         5'd6,  0, 0, 32'h0,        2'b10, 4'b0000, 32'h0,         32'h0);
    do_op(1'b1, 3'b010, 32'h0000_0204, 32'h0,         5'd7,  3, 2, 32'hCAFE_F00D, 2'b00, 4'b0000, 32'h0,         32'hCAFE_F00D);
    do_op(1'b1, 3'b010, 32'h0000_0008, 32'h0,         5'd0,  0, 0, 32'h1111_1111, 2'b00, 4'b0000, 32'h0,         32'h0);
    do_op(1'b1, 3'b101, 32'h0000_010E, 32'h0,         5'd31, 0, 1, 32'h8765_4321, 2'b00, 4'b0000, 32'h0,         32'h0000_8765);
    do_op(1'b1, 3'b001, 32'h0000_010E, 32'h0,         5'd3,  0, 0, 32'h8765_4321, 2'b00, 4'b0000, 32'h0,         32'hFFFF_8765);
    do_op(1'b1, 3'b000, 32'h0000_0011, 32'h0,         5'd4,  0, 0, 32'h0000_7F00, 2'b00, 4'b0000, 32'h0,         32'h0000_007F);
    do_op(1'b0, 3'b010, 32'h0000_0102, 32'h1,         5'd0,  0, 0, 32'h0,        2'b01, 4'b0000, 32'h0,         32'h0);
    do_op(1'b0, 3'b100, 32'h0000_0100, 32'h1,         5'd0,  0, 0, 32'h0,        2'b10, 4'b0000, 32'h0,         32'h0);

    // Reset while waiting for read data; the late RVALID must not write back
    i_req_valid = 1'b1; i_req_load = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 32'h0000_0040; i_req_rd = 5'd9;
    @(negedge CLK);
    check("rst_test_ready", {31'd0, o_req_ready}, 32'd1);
    mem_q.push_back('{1'b0, 32'h0000_0040, 4'b0000, 32'h0, cyc + 1});
    @(posedge CLK); #1;
    i_req_valid = 1'b0; i_mem_ready = 1'b1;
    @(posedge CLK); #1;
    i_mem_ready = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst_ready",     {31'd0, o_req_ready}, 32'd1);
    check("post_rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
    @(posedge CLK); #1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
    @(posedge CLK); #1;
    i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("late_rvalid_ready", {31'd0, o_req_ready}, 32'd1);

    check("mem_q_drained",  mem_q.size(),  32'd0);
    check("wb_q_drained",   wb_q.size(),   32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit for the core's memory stage. Accepts one decoded load or store per handshake, with the effective address already computed from RS1 plus the immediate and the store data taken from RS2. Drives a word-wide data-memory bus with byte strobes. Returns aligned, sign- or zero-extended load data to the register-file write port (WADDR/WE/WDATA).

## Interface
- No parameters; data width fixed at 32, register address at 5.
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  unit idle, request accepted on VALID&&READY
- REQ_LOAD  in  1  1 = load, 0 = store
- REQ_FUNCT3  in  3  RV32I width/sign code
- REQ_ADDR  in  32  effective byte address
- REQ_WDATA  in  32  store data (RS2)
- REQ_RD  in  5  load destination register
- MEM_VALID  out  1  bus request
- MEM_READY  in  1  bus accepts request
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  32  word address, {addr[31:2],2'b00}
- MEM_WSTRB  out  4  byte enables (0000 on loads)
- MEM_WDATA  out  32  lane-replicated store data
- MEM_RVALID  in  1  read data valid
- MEM_RDATA  in  32  read word
- WB_WE  out  1  one-cycle write pulse to register file
- WB_ADDR  out  5  destination register
- WB_DATA  out  32  extended load result
- DONE  out  1  one-cycle completion pulse
- EXC  out  1  exception pulse, coincident with DONE
- EXC_CAUSE  out  2  01 misaligned, 10 illegal funct3, 00 none

## Operation
- FSM states: IDLE, REQ, RWAIT, WB, FIN.
- REQ_READY = (state==IDLE).
- On accept, all REQ_* fields are latched and then checked:
  - Misaligned: half-word with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal: load funct3 outside {000,001,010,100,101}; store funct3 outside {000,001,010}.
- Faulting request: IDLE→FIN. No bus access, no WB_WE. EXC=1 with cause.
- Store path: IDLE→REQ→FIN.
  - WSTRB: byte 0001<<a, half 0011<<a, word 1111, where a=addr[1:0].
  - WDATA: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load path: IDLE→REQ→RWAIT→WB→FIN.
  - Capture MEM_RDATA on MEM_RVALID and shift right by 8*a.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- REQ→next state on MEM_READY. MEM_* outputs stay stable while MEM_VALID && !MEM_READY.
- WB: WB_WE=1 for one cycle, suppressed when rd==0. WB_ADDR/WB_DATA are updated in WB and held until the next load's WB. The register file samples its write enable one cycle late, so these two must remain stable for at least the cycle after the pulse.
- FIN: DONE=1 for one cycle, then return to IDLE.

## Timing
- Reset values: state IDLE, REQ_READY=1 from the first cycle after reset, all other outputs 0.
- All outputs are registered except REQ_READY.
- Store, zero-wait bus: accept at cycle 0, MEM_VALID at 1 (READY high), DONE at 2.
- Load, zero-wait bus: accept at 0, MEM_VALID at 1, RVALID at 2, WB_WE at 3, DONE at 4.
- Fault: accept at 0, DONE+EXC at 1.
- MEM_RVALID is honoured only in RWAIT. RVALID in the same cycle as MEM_READY is not allowed by the bus protocol.
- Reset mid-operation: return to IDLE next edge and drop MEM_VALID. Late MEM_RVALID is ignored. No WB_WE is issued.
- Back-to-back requests: the next accept is possible in the cycle after DONE.

## Structure
- Package core_lsu_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum, EXC_CAUSE codes.
- Sub-module core_lsu_align (combinational): misalign/illegal check, store strobe/data generation, load extract/extend.

## Test plan
- SW 0xDEADBEEF @0x100, zero-wait → MEM_WSTRB=1111, MEM_ADDR=0x100, DONE at cycle 2, no WB_WE.
- SB 0x000000A5 @0x103 → MEM_WSTRB=1000, MEM_WDATA=0xA5A5A5A5, MEM_ADDR=0x100.
- LB @0x102, RDATA=0x1280_3456, rd=5 → WB_DATA=0xFFFFFF80, WB_ADDR=5, WB_WE at cycle 3. Same access as LBU → 0x00000080.
- LH @0x101 → EXC=1, EXC_CAUSE=01, DONE at cycle 1, MEM_VALID never asserted. Load funct3=011 → EXC_CAUSE=10.
- LW with MEM_READY held low 3 cycles and RVALID 2 cycles later → MEM_* stable throughout, single WB_WE, WB_ADDR/WB_DATA held after the pulse. Load with rd=0 → no WB_WE, DONE still issued.
- RST_N low during RWAIT, then RVALID arrives → no WB_WE, REQ_READY=1 the cycle after reset.
